// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
interface imem_uart_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/imem_uart_loader.sv
// Boot-time loader: receives a length-prefixed 8N1 UART image, writes it word by word
// into imem and holds the core in reset until the image is complete.
module imem_uart_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                uart_rx,
  imem_uart_loader_if.master  imem,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err
);

  localparam int unsigned HALF     = CLKS_PER_BIT / 2;
  localparam int unsigned CW       = $clog2(CLKS_PER_BIT);
  localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_WORD, LD_WRITE, LD_DONE, LD_ERR} ld_state_t;

  logic rx_s1, rx_s2, rx_prev;

  rx_state_t rx_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          frame_err;

  ld_state_t         ld_state;
  logic [7:0]        len_lo;
  logic [15:0]       remaining;
  logic [1:0]        byte_idx;
  logic [23:0]       word_sr;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  assign imem.imem_we    = we_q;
  assign imem.imem_addr  = addr_q;
  assign imem.imem_wdata = wdata_q;

  // rx_prev gives the falling-edge detector a registered copy of the synchronized line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            baud_cnt <= '0;
          end
        end
        RX_START: begin
          if (baud_cnt == CW'(HALF - 1)) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            rx_byte  <= {rx_s2, rx_byte[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt == CW'(CLKS_PER_BIT - 1)) begin
            baud_cnt <= '0;
            if (rx_s2) byte_valid <= 1'b1;
            else       frame_err  <= 1'b1;
            rx_state <= RX_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state  <= LD_LEN_LO;
      len_lo    <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      word_sr   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (frame_err && ld_state != LD_DONE && ld_state != LD_ERR) begin
        ld_state <= LD_ERR;
        load_err <= 1'b1;
      end else begin
        case (ld_state)
          LD_LEN_LO: begin
            if (byte_valid) begin
              len_lo   <= rx_byte;
              ld_state <= LD_LEN_HI;
            end
          end
          LD_LEN_HI: begin
            if (byte_valid) begin
              remaining <= {rx_byte, len_lo};
              byte_idx  <= '0;
              if ({rx_byte, len_lo} == 16'd0) begin
                ld_state  <= LD_DONE;
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
              end else if ({1'b0, rx_byte, len_lo} > CAPACITY) begin
                ld_state <= LD_ERR;
                load_err <= 1'b1;
              end else begin
                ld_state <= LD_WORD;
              end
            end
          end
          LD_WORD: begin
            if (byte_valid) begin
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                wdata_q  <= {rx_byte, word_sr};
                we_q     <= 1'b1;
                ld_state <= LD_WRITE;
              end else begin
                word_sr <= {rx_byte, word_sr[23:8]};
              end
            end
          end
          // Address is left on the final word so it never wraps at full capacity
          LD_WRITE: begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              ld_state  <= LD_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              addr_q   <= addr_q + ADDR_W'(1);
              ld_state <= LD_WORD;
            end
          end
          LD_DONE, LD_ERR: ;
          default: ld_state <= LD_ERR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader with a stream-level reference model.
module tb_imem_uart_loader;
  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic cpu_hold, load_done, load_err;

  imem_uart_loader_if #(.ADDR_W(AW)) bus ();

  imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .imem      (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  int          cyc = 0;
  int          mon_addr[$];
  logic [31:0] mon_data[$];
  int          last_we_cyc = -1;
  int          hold_low_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mon_addr.delete();
      mon_data.delete();
      last_we_cyc = -1;
      hold_low_cyc = -1;
    end else begin
      if (bus.imem_we) begin
        mon_addr.push_back(int'(bus.imem_addr));
        mon_data.push_back(bus.imem_wdata);
        last_we_cyc = cyc;
      end
      if (!cpu_hold && hold_low_cyc < 0) hold_low_cyc = cyc;
    end
  end

  logic [7:0]  stim_b[$];
  logic        stim_stop[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_err;

  // Reference: interpret the byte stream directly (length header, words, first bad stop bit)
  task automatic model_run();
    int len, fe, n, avail, nw;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    len = stim_b.size();
    fe = len;
    for (int i = len - 1; i >= 0; i--) if (!stim_stop[i]) fe = i;
    if (fe < 2) begin
      exp_err = (fe < len);
      return;
    end
    n = int'(stim_b[0]) + 256 * int'(stim_b[1]);
    if (n == 0) begin
      exp_done = 1'b1;
      return;
    end
    if (n > 2 ** AW) begin
      exp_err = 1'b1;
      return;
    end
    avail = (fe - 2) / 4;
    nw = (n < avail) ? n : avail;
    for (int k = 0; k < nw; k++) begin
      exp_addr.push_back(k);
      exp_data.push_back({stim_b[2+4*k+3], stim_b[2+4*k+2], stim_b[2+4*k+1], stim_b[2+4*k]});
    end
    if (nw == n) exp_done = 1'b1;
    else         exp_err  = (fe < len);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    if (!stop) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_stream();
    for (int i = 0; i < stim_b.size(); i++) send_byte(stim_b[i], stim_stop[i]);
    repeat (30) @(negedge clk);
  endtask

  task automatic good_stops();
    stim_stop.delete();
    for (int i = 0; i < stim_b.size(); i++) stim_stop.push_back(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (bus.imem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we got %b want 0", bus.imem_we); end
    tests_run++; if (bus.imem_addr !== 8'd0) begin tests_failed++; $display("FAIL reset_addr got %h want 00", bus.imem_addr); end
    tests_run++; if (bus.imem_wdata !== 32'd0) begin tests_failed++; $display("FAIL reset_wdata got %h want 0", bus.imem_wdata); end
    tests_run++; if (cpu_hold !== 1'b1) begin tests_failed++; $display("FAIL reset_hold got %b want 1", cpu_hold); end
    tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", load_done); end
    tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", load_err); end
  endtask

  task automatic test_two_words(input string tag);
    stim_b = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
    good_stops();
    send_stream();
    tests_run++; if (mon_addr.size() !== 2) begin tests_failed++; $display("FAIL %s_nwrites got %0d want 2", tag, mon_addr.size()); end
    if (mon_addr.size() >= 2) begin
      tests_run++; if (mon_addr[0] !== 0 || mon_data[0] !== 32'h0000_0013) begin tests_failed++; $display("FAIL %s_w0 got %0d:%h want 0:00000013", tag, mon_addr[0], mon_data[0]); end
      tests_run++; if (mon_addr[1] !== 1 || mon_data[1] !== 32'h0050_0093) begin tests_failed++; $display("FAIL %s_w1 got %0d:%h want 1:00500093", tag, mon_addr[1], mon_data[1]); end
    end
    tests_run++; if (load_done !== 1'b1) begin tests_failed++; $display("FAIL %s_done got %b want 1", tag, load_done); end
    tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("FAIL %s_err got %b want 0", tag, load_err); end
    tests_run++; if (cpu_hold !== 1'b0) begin tests_failed++; $display("FAIL %s_hold got %b want 0", tag, cpu_hold); end
    tests_run++; if (hold_low_cyc !== last_we_cyc + 1) begin tests_failed++; $display("FAIL %s_hold_timing got cycle %0d want %0d", tag, hold_low_cyc, last_we_cyc + 1); end
  endtask

  task automatic test_zero_len();
    do_reset();
    stim_b = {8'h00, 8'h00};
    good_stops();
    send_stream();
    tests_run++; if (mon_addr.size() !== 0) begin tests_failed++; $display("FAIL zero_nwrites got %0d want 0", mon_addr.size()); end
    tests_run++; if (load_done !== 1'b1) begin tests_failed++; $display("FAIL zero_done got %b want 1", load_done); end
    tests_run++; if (cpu_hold !== 1'b0) begin tests_failed++; $display("FAIL zero_hold got %b want 0", cpu_hold); end
  endtask

  task automatic test_frame_err();
    do_reset();
    stim_b = {8'h01, 8'h00, 8'hAA, 8'h11, 8'h22, 8'h33, 8'h44};
    good_stops();
    stim_stop[2] = 1'b0;
    send_stream();
    tests_run++; if (load_err !== 1'b1) begin tests_failed++; $display("FAIL ferr_err got %b want 1", load_err); end
    tests_run++; if (cpu_hold !== 1'b1) begin tests_failed++; $display("FAIL ferr_hold got %b want 1", cpu_hold); end
    tests_run++; if (load_done !== 1'b0) begin tests_failed++; $display("FAIL ferr_done got %b want 0", load_done); end
    tests_run++; if (mon_addr.size() !== 0) begin tests_failed++; $display("FAIL ferr_nwrites got %0d want 0", mon_addr.size()); end
  endtask

  task automatic test_glitch();
    do_reset();
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    tests_run++; if (load_err !== 1'b0 || load_done !== 1'b0) begin tests_failed++; $display("FAIL glitch_status got done=%b err=%b want 0 0", load_done, load_err); end
    stim_b = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    good_stops();
    send_stream();
    tests_run++; if (mon_addr.size() !== 1) begin tests_failed++; $display("FAIL glitch_nwrites got %0d want 1", mon_addr.size()); end
    if (mon_addr.size() >= 1) begin
      tests_run++; if (mon_addr[0] !== 0 || mon_data[0] !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL glitch_w0 got %0d:%h want 0:deadbeef", mon_addr[0], mon_data[0]); end
    end
    tests_run++; if (load_done !== 1'b1) begin tests_failed++; $display("FAIL glitch_done got %b want 1", load_done); end
  endtask

  task automatic test_oversize();
    do_reset();
    stim_b = {8'h01, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88};
    good_stops();
    send_stream();
    tests_run++; if (load_err !== 1'b1) begin tests_failed++; $display("FAIL over_err got %b want 1", load_err); end
    tests_run++; if (cpu_hold !== 1'b1) begin tests_failed++; $display("FAIL over_hold got %b want 1", cpu_hold); end
    tests_run++; if (mon_addr.size() !== 0) begin tests_failed++; $display("FAIL over_nwrites got %0d want 0", mon_addr.size()); end
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h00, 1'b1);
    tests_run++; if (mon_addr.size() !== 0) begin tests_failed++; $display("FAIL mid_partial_writes got %0d want 0", mon_addr.size()); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.imem_we !== 1'b0 || bus.imem_addr !== 8'd0 || bus.imem_wdata !== 32'd0) begin tests_failed++; $display("FAIL mid_reset_bus got we=%b addr=%h wdata=%h want 0 00 0", bus.imem_we, bus.imem_addr, bus.imem_wdata); end
    tests_run++; if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_status got hold=%b done=%b err=%b want 1 0 0", cpu_hold, load_done, load_err); end
    reset = 1'b0;
    @(negedge clk);
    test_two_words("mid");
  endtask

  task automatic test_random();
    int mode, n, nbytes, bad;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      mode = $urandom_range(0, 3);
      n = (mode == 3) ? 257 + $urandom_range(0, 1000) : $urandom_range(1, 5);
      stim_b.delete();
      stim_b.push_back(8'(n));
      stim_b.push_back(8'(n >> 8));
      nbytes = (mode == 3) ? 3 : 4 * n;
      for (int i = 0; i < nbytes; i++) stim_b.push_back(8'($urandom));
      if (mode == 1) stim_b.push_back(8'($urandom));
      good_stops();
      if (mode == 1) stim_stop[stim_b.size() - 1] = 1'b0;
      if (mode == 2) begin
        bad = $urandom_range(0, stim_b.size() - 1);
        stim_stop[bad] = 1'b0;
      end
      model_run();
      send_stream();
      tests_run++; if (mon_addr.size() !== exp_addr.size()) begin tests_failed++; $display("FAIL rand%0d_nwrites got %0d want %0d", it, mon_addr.size(), exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && k < mon_addr.size(); k++) begin
        tests_run++; if (mon_addr[k] !== exp_addr[k] || mon_data[k] !== exp_data[k]) begin tests_failed++; $display("FAIL rand%0d_w%0d got %0d:%h want %0d:%h", it, k, mon_addr[k], mon_data[k], exp_addr[k], exp_data[k]); end
      end
      tests_run++; if (load_done !== exp_done || load_err !== exp_err) begin tests_failed++; $display("FAIL rand%0d_status got done=%b err=%b want %b %b", it, load_done, load_err, exp_done, exp_err); end
      tests_run++; if (cpu_hold !== !exp_done) begin tests_failed++; $display("FAIL rand%0d_hold got %b want %b", it, cpu_hold, !exp_done); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_two_words("basic");
    test_zero_len();
    test_frame_err();
    test_glitch();
    test_oversize();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
